// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key debouncer.
// KEY_LONG_PRESS_EN selects the wider counter used by long-press detection.
package key_pkg;

  // Per-key debounce FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } key_st_t;

  // 20 ms and 1 s at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int LONG_CYCLES_DEF     = 50000000;

  // Field layout of the MCU status byte
  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_PEND_LSB  = 4;
  localparam int STATUS_FIELD_W   = 4;

  // Counter width: the long-press count needs room for LONG_CYCLES,
  // otherwise only the debounce terminal value DEBOUNCE_CYCLES-1 must fit.
  function automatic int cnt_width(input int deb, input int lng, input bit long_en);
    int w;
    w = long_en ? $clog2(lng + 1) : $clog2(deb);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key/event bus between the board keys, the MCU and the debouncer.
// long_evt exists only when KEY_LONG_PRESS_EN is defined.
//
// Event protocol: press_evt, release_evt and long_evt are single-cycle
// strobes with no back-pressure. evt_pending is the sticky copy of
// press_evt; the consumer acknowledges by raising evt_clr for at least one
// cycle. A press arriving in the same cycle as a clear wins, so an event is
// never lost between poll and clear.
interface key_debounce_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0]   key;          // raw, active-low, asynchronous
  logic [NUM_KEYS-1:0]   evt_clr;      // per-key pending clear (level)
  logic [NUM_KEYS-1:0]   key_state;    // debounced level, 1 = pressed
  logic [NUM_KEYS-1:0]   press_evt;
  logic [NUM_KEYS-1:0]   release_evt;
  logic [NUM_KEYS-1:0]   evt_pending;
  logic [7:0]            status;       // drives MCU in_pin0
  logic [2*NUM_KEYS-1:0] dbg_state;    // packed per-key FSM state
`ifdef KEY_LONG_PRESS_EN
  logic [NUM_KEYS-1:0]   long_evt;
`endif

  // Board/MCU side
  modport master (
    output key, evt_clr,
    input  key_state, press_evt, release_evt, evt_pending, status, dbg_state
`ifdef KEY_LONG_PRESS_EN
    , input long_evt
`endif
  );

  // Debouncer side
  modport slave (
    input  key, evt_clr,
    output key_state, press_evt, release_evt, evt_pending, status, dbg_state
`ifdef KEY_LONG_PRESS_EN
    , output long_evt
`endif
  );

endinterface

// File: rtl/key_debounce_chan.sv
// One key: 2-flop synchroniser, debounce counter, 4-state FSM and the
// sticky pending flag. KEY_LONG_PRESS_EN adds held-phase counting and
// a one-shot long_evt per press.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    key,
  input  logic    evt_clr,
  output logic    key_state,
  output logic    press_evt,
  output logic    release_evt,
  output logic    evt_pending,
`ifdef KEY_LONG_PRESS_EN
  output logic    long_evt,
`endif
  output key_st_t dbg_state
);

`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, LONG_EN);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`endif

  logic             sync1, sync2;
  logic             ksync;
  key_st_t          state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             key_state_nx, press_nx, release_nx, pending_nx;
`ifdef KEY_LONG_PRESS_EN
  logic             long_flag, long_flag_nx, long_nx;
`endif

  // Two-flop synchroniser; resets to the released (high) pin level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  assign ksync = ~sync2;

  // State register, counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_state   <= 1'b0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      evt_pending <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
      long_flag   <= 1'b0;
      long_evt    <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      key_state   <= key_state_nx;
      press_evt   <= press_nx;
      release_evt <= release_nx;
      evt_pending <= pending_nx;
`ifdef KEY_LONG_PRESS_EN
      long_flag   <= long_flag_nx;
      long_evt    <= long_nx;
`endif
    end
  end

  // Next-state, counter and event decode
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    key_state_nx = key_state;
    press_nx     = 1'b0;
    release_nx   = 1'b0;
`ifdef KEY_LONG_PRESS_EN
    long_flag_nx = long_flag;
    long_nx      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (ksync) begin
          cnt_nx   = '0;
          state_nx = PRESS_CHK;
        end
      end
      PRESS_CHK: begin
        if (!ksync) begin
          // bounce: drop back without an event
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (cnt == DEB_LAST) begin
          cnt_nx       = '0;
          state_nx     = HELD;
          key_state_nx = 1'b1;
          press_nx     = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!ksync) begin
          cnt_nx   = '0;
          state_nx = REL_CHK;
        end
`ifdef KEY_LONG_PRESS_EN
        else if (cnt == LONG_LAST) begin
          // saturate; the flag makes the pulse one-shot per press
          if (!long_flag) begin
            long_nx      = 1'b1;
            long_flag_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
`endif
      end
      REL_CHK: begin
        if (ksync) begin
          // release glitch: back to held, long flag kept
          cnt_nx   = '0;
          state_nx = HELD;
        end else if (cnt == DEB_LAST) begin
          cnt_nx       = '0;
          state_nx     = IDLE;
          key_state_nx = 1'b0;
          release_nx   = 1'b1;
`ifdef KEY_LONG_PRESS_EN
          long_flag_nx = 1'b0;
`endif
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    // set has priority over clear so a press is never swallowed
    pending_nx = press_nx | (evt_pending & ~evt_clr);
  end

  assign dbg_state = state;

endmodule

// File: rtl/key_debounce.sv
// Top: NUM_KEYS independent debounce channels plus the packed MCU status
// byte {pending[3:0], state[3:0]}, unused bits tied low.
// KEY_LONG_PRESS_EN enables long-press events on the bus.
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  key_debounce_if.slave bus
);

  logic [NUM_KEYS-1:0]   key_state_v;
  logic [NUM_KEYS-1:0]   press_v;
  logic [NUM_KEYS-1:0]   release_v;
  logic [NUM_KEYS-1:0]   pending_v;
`ifdef KEY_LONG_PRESS_EN
  logic [NUM_KEYS-1:0]   long_v;
`endif
  key_st_t               st_v [NUM_KEYS];
  logic [7:0]            status_c;
  logic [2*NUM_KEYS-1:0] dbg_c;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_chan (
      .clk         (sys_clk),
      .rst_n       (sys_rst_n),
      .key         (bus.key[i]),
      .evt_clr     (bus.evt_clr[i]),
      .key_state   (key_state_v[i]),
      .press_evt   (press_v[i]),
      .release_evt (release_v[i]),
      .evt_pending (pending_v[i]),
`ifdef KEY_LONG_PRESS_EN
      .long_evt    (long_v[i]),
`endif
      .dbg_state   (st_v[i])
    );
  end

  // Pack the status byte; fields are zero-padded to 4 bits
  always_comb begin
    status_c = '0;
    status_c[STATUS_STATE_LSB +: STATUS_FIELD_W] = STATUS_FIELD_W'(key_state_v);
    status_c[STATUS_PEND_LSB  +: STATUS_FIELD_W] = STATUS_FIELD_W'(pending_v);
  end

  // Pack per-key FSM states for observation
  always_comb begin
    dbg_c = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      dbg_c[2*i +: 2] = st_v[i];
    end
  end

  assign bus.key_state   = key_state_v;
  assign bus.press_evt   = press_v;
  assign bus.release_evt = release_v;
  assign bus.evt_pending = pending_v;
  assign bus.status      = status_c;
  assign bus.dbg_state   = dbg_c;
`ifdef KEY_LONG_PRESS_EN
  assign bus.long_evt    = long_v;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with short debounce/long constants. A reference
// model built from the acceptance rule (a level is accepted once the
// synchronised pin has shown it for DEBOUNCE_CYCLES+1 consecutive samples)
// feeds an expected queue that is checked every cycle.
module tb_key_debounce;

  localparam int N = 4;
  localparam int D = 16;
  localparam int L = 64;
  localparam int W = 5 * N;

  logic sys_clk;
  logic sys_rst_n;

  key_debounce_if #(.NUM_KEYS(N)) bus ();

  key_debounce #(
    .NUM_KEYS        (N),
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];

  bit pipe0 [N];
  bit pipe1 [N];
  bit m_state [N];
  bit m_pend [N];
  bit prev_s [N];
  bit lfired [N];
  int run [N];
  int lrun [N];
  bit s_v, was_held;
  logic [N-1:0] e_state, e_press, e_rel, e_pend, e_long;

  always @(posedge sys_clk) begin
    e_state = '0; e_press = '0; e_rel = '0; e_pend = '0; e_long = '0;
    for (int k = 0; k < N; k++) begin
      if (!sys_rst_n) begin
        pipe0[k] = 0; pipe1[k] = 0; m_state[k] = 0; m_pend[k] = 0;
        prev_s[k] = 0; lfired[k] = 0; run[k] = 0; lrun[k] = 0;
      end else begin
        // pressed level as seen through two flops of delay
        s_v      = pipe1[k];
        pipe1[k] = pipe0[k];
        pipe0[k] = ~bus.key[k];
        was_held = m_state[k];
        if (s_v != m_state[k]) run[k]++;
        else run[k] = 0;
        if (run[k] == D + 1) begin
          run[k]     = 0;
          m_state[k] = s_v;
          if (s_v) begin
            e_press[k] = 1'b1;
            lrun[k]    = 0;
          end else begin
            e_rel[k]  = 1'b1;
            lfired[k] = 0;
          end
        end else if (was_held) begin
          // held time restarts after any sample showing the key released
          if (!s_v || !prev_s[k]) lrun[k] = 0;
          else begin
            lrun[k]++;
            if (lrun[k] == L && !lfired[k]) begin
              e_long[k] = 1'b1;
              lfired[k] = 1;
            end
          end
        end
        m_pend[k] = e_press[k] | (m_pend[k] & ~bus.evt_clr[k]);
        prev_s[k] = s_v;
      end
      e_state[k] = m_state[k];
      e_pend[k]  = m_pend[k];
    end
    exp_q.push_back({e_long, e_pend, e_rel, e_press, e_state});
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_w;
  logic [N-1:0] x_state, x_press, x_rel, x_pend, x_long;

  always @(negedge sys_clk) begin
    check("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      {x_long, x_pend, x_rel, x_press, x_state} = exp_w;
      check("key_state", bus.key_state, x_state);
      check("press_evt", bus.press_evt, x_press);
      check("release_evt", bus.release_evt, x_rel);
      check("evt_pending", bus.evt_pending, x_pend);
      check("status", bus.status, {4'(x_pend), 4'(x_state)});
`ifdef KEY_LONG_PRESS_EN
      check("long_evt", bus.long_evt, x_long);
`endif
    end
  end

  // event counters (sample the previous cycle's registered outputs)
  int press_seen [N];
  int long_seen [N];
  initial for (int k = 0; k < N; k++) begin press_seen[k] = 0; long_seen[k] = 0; end
  always @(posedge sys_clk) begin
    for (int k = 0; k < N; k++) begin
      if (bus.press_evt[k] === 1'b1) press_seen[k]++;
`ifdef KEY_LONG_PRESS_EN
      if (bus.long_evt[k] === 1'b1) long_seen[k]++;
`endif
    end
  end

  // ---------------- stimulus ----------------
  int hold_left [N];

  initial begin
    sys_rst_n   = 1'b0;
    bus.key     = '1;
    bus.evt_clr = '0;
    tick(3);
    check("rst_status", bus.status, 8'h00);
    check("rst_key_state", bus.key_state, 4'h0);
    check("rst_dbg_state", bus.dbg_state, 8'h00);
    sys_rst_n = 1'b1;
    tick(5);

    // clean press on key 0
    bus.key[0] = 1'b0;
    tick(18);
    check("press0_early", bus.press_evt, 4'h0);
    tick(1);
    check("press0_pulse", bus.press_evt, 4'h1);
    check("press0_state", bus.key_state, 4'h1);
    check("press0_status", bus.status, 8'h11);
    bus.evt_clr[0] = 1'b1;
    tick(1);
    bus.evt_clr[0] = 1'b0;
    check("clr0_status", bus.status, 8'h01);
    check("press0_once", bus.press_evt, 4'h0);

    // bounce rejection on key 1
    bus.key[1] = 1'b0; tick(10);
    bus.key[1] = 1'b1; tick(3);
    bus.key[1] = 1'b0; tick(10);
    bus.key[1] = 1'b1; tick(25);
    check("bounce1_no_press", press_seen[1], 0);
    check("bounce1_state", bus.key_state[1], 1'b0);
    bus.key[1] = 1'b0; tick(22);
    check("hold1_one_press", press_seen[1], 1);
    bus.key[1] = 1'b1; tick(25);

    // release of key 0
    bus.key[0] = 1'b1;
    tick(18);
    check("rel0_early", bus.release_evt, 4'h0);
    tick(1);
    check("rel0_pulse", bus.release_evt, 4'h1);
    check("rel0_state", bus.key_state, 4'h0);
    check("rel0_pend", bus.evt_pending[0], 1'b0);
    check("rel0_status", bus.status, 8'h20);
    bus.evt_clr = '1; tick(1); bus.evt_clr = '0; tick(2);

    // set/clear collision on key 2
    bus.evt_clr[2] = 1'b1;
    bus.key[2] = 1'b0;
    tick(19);
    check("coll2_press", bus.press_evt, 4'h4);
    check("coll2_pend_set", bus.evt_pending[2], 1'b1);
    tick(1);
    check("coll2_pend_clr", bus.evt_pending[2], 1'b0);
    bus.evt_clr[2] = 1'b0;
    bus.key[2] = 1'b1;
    tick(25);

    // reset mid-debounce on key 3
    bus.key[3] = 1'b0;
    tick(10);
    sys_rst_n = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
    check("rst3_no_press", press_seen[3], 0);
    check("rst3_status", bus.status, 8'h00);
    tick(18);
    check("rst3_early", bus.press_evt, 4'h0);
    tick(1);
    check("rst3_press", bus.press_evt, 4'h8);
    bus.key[3] = 1'b1;
    tick(25);

`ifdef KEY_LONG_PRESS_EN
    // long press on key 0, then a short release glitch
    bus.key[0] = 1'b0;
    tick(19);
    check("long0_press", bus.press_evt, 4'h1);
    tick(63);
    check("long0_early", bus.long_evt, 4'h0);
    tick(1);
    check("long0_pulse", bus.long_evt, 4'h1);
    tick(10);
    bus.key[0] = 1'b1; tick(5);
    bus.key[0] = 1'b0; tick(100);
    check("long0_once", long_seen[0], 1);
    bus.key[0] = 1'b1;
    tick(25);
`endif

    // randomized key activity, clears and occasional resets
    for (int k = 0; k < N; k++) hold_left[k] = $urandom_range(1, 40);
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (hold_left[k] == 0) begin
          bus.key[k] = ~bus.key[k];
          hold_left[k] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 12)
                                                    : $urandom_range(14, 110);
        end else begin
          hold_left[k]--;
        end
      end
      bus.evt_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      sys_rst_n   = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    sys_rst_n   = 1'b1;
    bus.evt_clr = '0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Per-key debouncer and event latcher for the board push-buttons.
- Sits directly upstream of the MCU input port: its packed status byte drives in_pin0 in place of the raw key wires.
- Synchronises the raw active-low keys and filters bounce with per-key counters.
- Emits press/release pulses and sticky pending flags that the MCU firmware polls and clears.

Parameters:
- NUM_KEYS, 4: number of keys; 1..4.
- DEBOUNCE_CYCLES, 1000000: stable cycles required before accepting a level change (20 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 50000000: held cycles to flag a long press (1 s at 50 MHz); used only with the optional feature.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  reset, synchronous, active-low.
- key  in  NUM_KEYS  raw key inputs; active-low, asynchronous.
- evt_clr  in  NUM_KEYS  per-key clear of evt_pending; level, sampled each cycle.
- key_state  out  NUM_KEYS  debounced level; 1 = pressed.
- press_evt  out  NUM_KEYS  1-cycle pulse on an accepted press.
- release_evt  out  NUM_KEYS  1-cycle pulse on an accepted release.
- evt_pending  out  NUM_KEYS  sticky: set by press_evt, cleared by evt_clr.
- status  out  8  {evt_pending zero-padded to 4 bits, key_state zero-padded to 4 bits}; drives MCU in_pin0.

Behaviour:
- One clock domain. Reset is synchronous, active-low, and sampled only on the sys_clk rising edge.
- Reset values:
  - synchroniser flops = 1 (released);
  - counters = 0;
  - all FSMs in IDLE;
  - all outputs = 0.
- Synchroniser: two flops per key; ksync = inverted second-stage output (1 = pressed).
- Per-key FSM has four states: IDLE, PRESS_CHK, HELD, REL_CHK.
  - IDLE: if ksync = 1, clear the counter and go to PRESS_CHK.
  - PRESS_CHK: if ksync = 1, increment the counter. When the counter reaches DEBOUNCE_CYCLES-1, go to HELD, set key_state, pulse press_evt, and clear the counter. If ksync = 0 first, return to IDLE with the counter cleared (glitch rejected; no event).
  - HELD: if ksync = 0, clear the counter and go to REL_CHK.
  - REL_CHK: mirror of PRESS_CHK. On reaching DEBOUNCE_CYCLES-1, go to IDLE, clear key_state, and pulse release_evt. If ksync = 1 first, return to HELD.
- Latency: a clean raw edge appears on key_state and the event pulse exactly DEBOUNCE_CYCLES+3 cycles after the key pin changes. That is 2 synchroniser cycles, 1 FSM entry cycle, and DEBOUNCE_CYCLES-1 counts, plus the registered output.
- key_state and the event pulses are registered and change in the same cycle.
- Counter width is $clog2(LONG_CYCLES+1) and must never wrap. Counting saturates at the terminal value.
- evt_pending[i]:
  - set when press_evt[i] = 1;
  - else cleared when evt_clr[i] = 1;
  - if both occur in the same cycle, set wins, so no event is lost.
- Holding evt_clr high continuously suppresses only events that have already been cleared. A new press still sets the flag for at least 1 cycle.
- Keys are fully independent. Simultaneous presses on several keys produce simultaneous pulses.
- Reset mid-debounce: all state is discarded, and no event is emitted for a press already in progress. After reset release, a key still held is detected as a fresh press after DEBOUNCE_CYCLES+3 cycles.
- Unused status bits (above NUM_KEYS) are tied to 0.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Defined:
  - adds output long_evt [NUM_KEYS], a 1-cycle pulse.
  - In HELD the counter keeps counting. When it reaches LONG_CYCLES-1, long_evt pulses once per press and the counter saturates.
  - Leaving HELD for REL_CHK does not reset the long-flag. Returning to HELD from REL_CHK (a release glitch) must not re-fire long_evt.
  - The long-flag is cleared on the transition to IDLE.
- Undefined: no long_evt port, no held-phase counting, smaller counter (width $clog2(DEBOUNCE_CYCLES)).

Decomposition:
- Package key_pkg holds:
  - the FSM state enum (key_st_t: IDLE, PRESS_CHK, HELD, REL_CHK);
  - the default constants DEBOUNCE_CYCLES_DEF and LONG_CYCLES_DEF;
  - the status-byte field offsets (STATUS_STATE_LSB = 0, STATUS_PEND_LSB = 4).
- Sub-module key_debounce_chan contains the synchroniser, counter, FSM, and pending flag for one key. The top generates NUM_KEYS instances and packs status.

Test Plan (DEBOUNCE_CYCLES=16, LONG_CYCLES=64):
- Clean press: key[0] 1->0 and held.
  - At cycle 19: press_evt[0] pulses for 1 cycle, key_state=0001, status=8'h11.
  - evt_clr[0]=1 for 1 cycle -> status=8'h01.
- Bounce rejection: key[1] low 10 cycles, high 3, low 10, then high. No press_evt, key_state[1] stays 0. Then key[1] held low 20 cycles -> single press_evt[1].
- Release: key[0] held, then 0->1.
  - After 19 cycles: release_evt[0] pulses, key_state=0000.
  - evt_pending is unaffected by the release.
- Set/clear collision: evt_clr[2] held high during an accepted press of key 2 -> evt_pending[2]=1 in the pulse cycle, 0 the next cycle.
- Reset mid-debounce: key[3] low, sys_rst_n=0 at cycle 10 for 2 cycles, then released with the key still held. No event before reset; press_evt[3] pulses 19 cycles after reset release.
- KEY_LONG_PRESS_EN: key[0] held 100 cycles.
  - press_evt at cycle 19, long_evt exactly once 64 cycles later.
  - A 5-cycle release glitch afterwards produces no second long_evt.
